legv8_instr_encoder: RTL and testbench
======================================

# legv8_instr_encoder

Streaming LEGv8 instruction encoder and program loader; the inverse of the single-cycle control decode path. It accepts symbolic instructions (operation select plus register and immediate fields) over a valid/ready handshake. It packs each one into a 32-bit machine word and writes the words sequentially into instruction memory through a one-entry registered output stage with backpressure. Test benches and the boot loader use it to build programs for the single-cycle processor.

## Interface
- ADDR_WIDTH, 16: byte-address width of the instruction-memory write port.
- DEPTH, 1024: number of words the loader may write before asserting Full (DEPTH*4 ≤ 2^ADDR_WIDTH).
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous restart: drops the pending word, WrAddr←0, count←0.
- InValid  in  1  instruction fields valid.
- InReady  out  1  encoder can accept this cycle.
- Op  in  3  0=LDUR 1=STUR 2=ADD 3=SUB 4=AND 5=ORR 6=CBZ 7=B.
- Rd  in  5  Rd (R-format) or Rt (D/CB); ignored for B.
- Rn  in  5  Rn (R/D); ignored for CB/B.
- Rm  in  5  Rm (R-format only).
- Imm  in  26  signed immediate: DT_address (D), COND_BR_address (CB), BR_address (B).
- WrValid  out  1  WrData/WrAddr hold a word to write.
- WrReady  in  1  memory accepts the word this cycle.
- WrAddr  out  ADDR_WIDTH  byte address of the pending word.
- WrData  out  32  encoded instruction.
- Full  out  1  DEPTH words written.
- Err  out  1  one-cycle pulse: accepted instruction had an out-of-range immediate (only with the macro).

## Operation
- Encoding: R: {opc11, Rm, 6'b0, Rn, Rd}. D: {opc11, Imm[8:0], 2'b00, Rn, Rt}. CB: {8'b10110100, Imm[18:0], Rt}. B: {6'b000101, Imm[25:0]}.
- opc11 values: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- States:
  - IDLE: no pending word.
  - PEND: WrValid=1.
  - FULL: count==DEPTH.
- Transitions:
  - IDLE→PEND on accept.
  - PEND→IDLE on write handshake with no new accept.
  - PEND→PEND on write handshake plus simultaneous accept.
  - Any state→FULL on the write handshake that makes count==DEPTH.
  - FULL→IDLE only on Clear.
- InReady = !Full && !Clear && (!WrValid || WrReady).
- Accept = InValid && InReady. Encoded word is registered into WrData on the accepting edge.
- Write handshake = WrValid && WrReady. After it: WrAddr += 4 (modulo 2^ADDR_WIDTH), count += 1.
- Clear has priority over every other event in the same cycle. A pending word is discarded and not written.
- While WrValid=1 && WrReady=0: WrData and WrAddr are held stable.

## Timing
- Reset values: InReady=1, WrValid=0, WrAddr=0, WrData=0, Full=0, Err=0, state IDLE, count=0.
- Latency: accept at edge N → WrValid=1 with WrData after edge N. Full throughput is 1 word/cycle when WrReady is held high.
- Full rises the cycle after the DEPTH-th write handshake. InReady is 0 in that same cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately. The pending word is lost.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - D requires Imm in −256..255; CB requires −2^18..2^18−1.
  - Out-of-range instruction is accepted (InReady rules unchanged) but dropped: no word, WrAddr/count unchanged.
  - Err pulses 1 cycle after acceptance.
- Not defined:
  - Imm is truncated to the field width and always written.
  - Err is tied to 0.

## Test plan
- Reset, then ADD Rd=1 Rn=2 Rm=3 with WrReady=1 → WrValid next cycle, WrData=0x8B030041, WrAddr=0; WrAddr=4 afterwards.
- Back-to-back LDUR Rt=9 Rn=10 Imm=8; CBZ Rt=5 Imm=−2; B Imm=−1 → WrData 0xF8408149 @0, 0xB4FFFFC5 @4, 0x17FFFFFF @8, on consecutive cycles.
- Hold WrReady=0 for 3 cycles with InValid=1 → InReady=0, WrData/WrAddr stable; on release exactly one write, then the next word follows.
- STUR Rt=1 Rn=2 Imm=256:
  - with ENC_RANGE_CHECK_EN → Err pulse, no WrValid, WrAddr unchanged;
  - without → WrData=0xF8100041.
- DEPTH=4, five instructions → four writes (WrAddr 0,4,8,12), Full=1, InReady=0. Clear → Full=0, WrAddr=0, fifth instruction written at 0.
- Assert Reset while PEND with WrReady=0 → WrValid=0, WrAddr=0 immediately (asynchronously); no write after release.

Source files
------------

// File: rtl/legv8_instr_encoder.sv
// -----------------------------------------------------------------------------
// legv8_instr_encoder
//
// Streaming LEGv8 instruction encoder and program loader. Symbolic instructions
// (operation select plus register/immediate fields) are accepted over a
// valid/ready handshake, packed into 32-bit machine words and written to
// consecutive word addresses of instruction memory through a one-entry
// registered output stage that honours memory backpressure.
//
// Parameters
//   ADDR_WIDTH : byte-address width of the memory write port
//   DEPTH      : number of words written before Full is raised
//
// Ports
//   CLK      in   clock, rising edge
//   Reset    in   asynchronous active-high reset
//   Clear    in   synchronous restart (drops pending word, address/count to 0)
//   InValid  in   instruction fields valid
//   InReady  out  encoder can accept this cycle
//   Op       in   0=LDUR 1=STUR 2=ADD 3=SUB 4=AND 5=ORR 6=CBZ 7=B
//   Rd       in   Rd (R-format) or Rt (D/CB)
//   Rn       in   Rn (R/D)
//   Rm       in   Rm (R-format)
//   Imm      in   signed immediate (DT / COND_BR / BR address)
//   WrValid  out  pending word present on WrData/WrAddr
//   WrReady  in   memory accepts the pending word
//   WrAddr   out  byte address of the pending word
//   WrData   out  encoded instruction word
//   Full     out  DEPTH words have been written
//   Err      out  one-cycle pulse for a dropped out-of-range immediate
//
// Optional feature: define ENC_RANGE_CHECK_EN to reject D/CB immediates that
// do not fit their field (instruction is consumed but no word is produced and
// Err pulses). Without it immediates are truncated and Err is held at 0.
// -----------------------------------------------------------------------------
module legv8_instr_encoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2:0]            Op,
    input  logic [4:0]            Rd,
    input  logic [4:0]            Rn,
    input  logic [4:0]            Rm,
    input  logic [25:0]           Imm,
    output logic                  WrValid,
    input  logic                  WrReady,
    output logic [ADDR_WIDTH-1:0] WrAddr,
    output logic [31:0]           WrData,
    output logic                  Full,
    output logic                  Err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [31:0]           data_q,  data_d;

    logic [31:0] enc_word;
    logic        range_ok;
    logic        accept;
    logic        wr_hs;
    logic        keep;

    // Instruction packing for the four LEGv8 formats.
    always_comb begin
        enc_word = 32'd0;
        case (Op)
            3'd0:    enc_word = {11'b11111000010, Imm[8:0], 2'b00, Rn, Rd};
            3'd1:    enc_word = {11'b11111000000, Imm[8:0], 2'b00, Rn, Rd};
            3'd2:    enc_word = {11'b10001011000, Rm, 6'b000000, Rn, Rd};
            3'd3:    enc_word = {11'b11001011000, Rm, 6'b000000, Rn, Rd};
            3'd4:    enc_word = {11'b10001010000, Rm, 6'b000000, Rn, Rd};
            3'd5:    enc_word = {11'b10101010000, Rm, 6'b000000, Rn, Rd};
            3'd6:    enc_word = {8'b10110100, Imm[18:0], Rd};
            default: enc_word = {6'b000101, Imm};
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A value fits a signed N-bit field when every bit above the field's
    // sign bit equals that sign bit.
    always_comb begin
        range_ok = 1'b1;
        if (Op == 3'd0 || Op == 3'd1)
            range_ok = (&Imm[25:8]) | ~(|Imm[25:8]);
        else if (Op == 3'd6)
            range_ok = (&Imm[25:18]) | ~(|Imm[25:18]);
    end
`else
    assign range_ok = 1'b1;
`endif

    assign WrValid = (state_q == ST_PEND);
    assign Full    = (state_q == ST_FULL);
    assign WrAddr  = addr_q;
    assign WrData  = data_q;

    // A new instruction may enter while the slot is empty or is being drained
    // this very cycle, which gives one word per cycle under continuous ready.
    assign InReady = !Full && !Clear && (!WrValid || WrReady);
    assign accept  = InValid && InReady;
    assign wr_hs   = WrValid && WrReady;
    assign keep    = accept && range_ok;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (Clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            addr_d  = '0;
        end else begin
            if (wr_hs) begin
                addr_d  = addr_q + ADDR_WIDTH'(4);
                count_d = count_q + CNT_W'(1);
            end
            // The write that reaches DEPTH dominates; a word accepted on that
            // same edge has no slot left and is not kept.
            if (wr_hs && (count_q == CNT_W'(DEPTH - 1))) begin
                state_d = ST_FULL;
            end else if (keep) begin
                state_d = ST_PEND;
                data_d  = enc_word;
            end else if (wr_hs) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_q, err_d;

    assign err_d = accept && !range_ok;
    assign Err   = err_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_instr_encoder.sv
module tb_legv8_instr_encoder;

    localparam int AW = 16;
    localparam int DP = 4;

    logic          CLK = 1'b0;
    logic          Reset, Clear, InValid, InReady;
    logic [2:0]    Op;
    logic [4:0]    Rd, Rn, Rm;
    logic [25:0]   Imm;
    logic          WrValid, WrReady;
    logic [AW-1:0] WrAddr;
    logic [31:0]   WrData;
    logic          Full, Err;

    legv8_instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .CLK(CLK), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(InReady),
        .Op(Op), .Rd(Rd), .Rn(Rn), .Rm(Rm), .Imm(Imm),
        .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
        .Full(Full), .Err(Err)
    );

    always #5 CLK = ~CLK;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];
    int           wr_cyc[$];
    logic [AW-1:0] exp_addr = '0;
    bit           err_exp = 1'b0;
    bit           rnd_rdy = 1'b0;
    int           cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrapm(input longint v, input longint m);
        return ((v % m) + m) % m;
    endfunction

    function automatic logic [31:0] model_enc(input int op, input int rd, input int rn,
                                              input int rm, input logic [25:0] imm);
        longint opc, w, s;
        s = longint'($signed(imm));
        case (op)
            0: opc = 'b11111000010;
            1: opc = 'b11111000000;
            2: opc = 'b10001011000;
            3: opc = 'b11001011000;
            4: opc = 'b10001010000;
            5: opc = 'b10101010000;
            default: opc = 0;
        endcase
        if (op <= 1)      w = opc * 2097152 + wrapm(s, 512) * 4096 + rn * 32 + rd;
        else if (op <= 5) w = opc * 2097152 + rm * 65536 + rn * 32 + rd;
        else if (op == 6) w = 180 * 16777216 + wrapm(s, 524288) * 32 + rd;
        else              w = 5 * 67108864 + wrapm(s, 67108864);
        return w[31:0];
    endfunction

    function automatic bit model_drop(input int op, input logic [25:0] imm);
        int s;
        s = int'($signed(imm));
`ifdef ENC_RANGE_CHECK_EN
        if (op <= 1) return (s < -256 || s > 255);
        if (op == 6) return (s < -262144 || s > 262143);
`endif
        return (op < 0) && (s == 0);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        cyc++;
        if (Reset) begin
            exp_q.delete();
            exp_addr = '0;
            err_exp  = 1'b0;
        end else begin
            check("err_flag", {31'd0, Err}, {31'd0, err_exp});
            err_exp = 1'b0;
            if (Clear) begin
                exp_q.delete();
                exp_addr = '0;
            end else if (WrValid && WrReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", WrData, 32'hxxxxxxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("wr_data", WrData, e);
                    check("wr_addr", {16'd0, WrAddr}, {16'd0, exp_addr});
                end
                exp_addr = exp_addr + 16'd4;
                wr_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rnd_rdy) WrReady = 1'($urandom_range(0, 1));
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm,
                        input logic [31:0] exp, input bit drop);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        Op = op; Rd = rd; Rn = rn; Rm = rm; Imm = imm; InValid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge CLK);
            if (InReady) ok = 1'b1;
            else n++;
        end
        @(posedge CLK); #1;
        InValid = 1'b0;
        check("send_accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            if (!drop) exp_q.push_back(exp);
            err_exp = drop;
        end
    endtask

    task automatic send_rand();
        int op, t;
        logic [4:0] rd, rn, rm;
        logic [25:0] imm;
        op = $urandom_range(0, 7);
        rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
        case ($urandom_range(0, 2))
            0: t = $urandom_range(0, 600) - 300;
            1: t = (($urandom_range(0, 1) == 1) ? 262144 : -262144) + $urandom_range(0, 6) - 3;
            default: t = int'($urandom);
        endcase
        imm = t[25:0];
        send(3'(op), rd, rn, rm, imm, model_enc(op, rd, rn, rm, imm), model_drop(op, imm));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("drain_done", exp_q.size(), 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        @(posedge CLK); #1;
        Clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit stur_drop;
`ifdef ENC_RANGE_CHECK_EN
        stur_drop = 1'b1;
`else
        stur_drop = 1'b0;
`endif
        Reset = 1'b1; Clear = 1'b0; InValid = 1'b0; WrReady = 1'b0;
        Op = '0; Rd = '0; Rn = '0; Rm = '0; Imm = '0;

        @(negedge CLK);
        check("rst_inready", {31'd0, InReady}, 32'd1);
        check("rst_wrvalid", {31'd0, WrValid}, 32'd0);
        check("rst_wraddr", {16'd0, WrAddr}, 32'd0);
        check("rst_wrdata", WrData, 32'd0);
        check("rst_full", {31'd0, Full}, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0; WrReady = 1'b1;

        // Single ADD
        send(3'd2, 5'd1, 5'd2, 5'd3, 26'd0, 32'h8B030041, 1'b0);
        check("add_wrvalid", {31'd0, WrValid}, 32'd1);
        @(posedge CLK); #1;
        check("add_addr_after", {16'd0, WrAddr}, 32'd4);
        check("add_idle_after", {31'd0, WrValid}, 32'd0);
        wait_drain();

        // Back-to-back LDUR / CBZ / B
        do_clear();
        wr_cyc.delete();
        send(3'd0, 5'd9, 5'd10, 5'd0, 26'd8, 32'hF8408149, 1'b0);
        send(3'd6, 5'd5, 5'd0, 5'd0, 26'h3FFFFFE, 32'hB4FFFFC5, 1'b0);
        send(3'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 32'h17FFFFFF, 1'b0);
        wait_drain();
        check("b2b_count", wr_cyc.size(), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("b2b_gap1", wr_cyc[1] - wr_cyc[0], 32'd1);
            check("b2b_gap2", wr_cyc[2] - wr_cyc[1], 32'd1);
        end

        // Backpressure: ORR held while SUB waits
        do_clear();
        WrReady = 1'b0;
        send(3'd5, 5'd4, 5'd5, 5'd6, 26'd0, 32'hAA0600A4, 1'b0);
        Op = 3'd3; Rd = 5'd7; Rn = 5'd8; Rm = 5'd9; Imm = 26'd0; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_inready", {31'd0, InReady}, 32'd0);
            check("stall_wrvalid", {31'd0, WrValid}, 32'd1);
            check("stall_data", WrData, 32'hAA0600A4);
            check("stall_addr", {16'd0, WrAddr}, 32'd0);
        end
        @(posedge CLK); #1;
        WrReady = 1'b1;
        send(3'd3, 5'd7, 5'd8, 5'd9, 26'd0, 32'hCB090107, 1'b0);
        wait_drain();
        check("stall_final_addr", {16'd0, WrAddr}, 32'd8);

        // STUR with DT_address 256 (out of range for the 9-bit field)
        do_clear();
        send(3'd1, 5'd1, 5'd2, 5'd0, 26'd256, 32'hF8100041, stur_drop);
        wait_drain();
        check("stur_addr", {16'd0, WrAddr}, stur_drop ? 32'd0 : 32'd4);

        // Fill to DEPTH, blocked fifth, Clear, fifth at 0
        do_clear();
        for (int i = 0; i < DP; i++)
            send(3'd2, 5'(i + 1), 5'd2, 5'd3, 26'd0, model_enc(2, i + 1, 2, 3, 26'd0), 1'b0);
        n = 0;
        while (!Full && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("full_set", {31'd0, Full}, 32'd1);
        check("full_inready", {31'd0, InReady}, 32'd0);
        check("full_wrvalid", {31'd0, WrValid}, 32'd0);
        check("full_addr", {16'd0, WrAddr}, 32'd16);
        @(posedge CLK); #1;
        Op = 3'd4; Rd = 5'd11; Rn = 5'd12; Rm = 5'd13; Imm = 26'd0; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("full_block", {31'd0, InReady}, 32'd0);
        end
        @(posedge CLK); #1;
        Clear = 1'b1;
        @(negedge CLK);
        check("clear_inready", {31'd0, InReady}, 32'd0);
        @(posedge CLK); #1;
        Clear = 1'b0;
        check("clear_full", {31'd0, Full}, 32'd0);
        check("clear_addr", {16'd0, WrAddr}, 32'd0);
        send(3'd4, 5'd11, 5'd12, 5'd13, 26'd0, model_enc(4, 11, 12, 13, 26'd0), 1'b0);
        wait_drain();

        // Asynchronous reset while a word is pending
        do_clear();
        WrReady = 1'b0;
        send(3'd2, 5'd3, 5'd3, 5'd3, 26'd0, model_enc(2, 3, 3, 3, 26'd0), 1'b0);
        #2 Reset = 1'b1;
        #1;
        check("arst_wrvalid", {31'd0, WrValid}, 32'd0);
        check("arst_wraddr", {16'd0, WrAddr}, 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0; WrReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("arst_no_write", {31'd0, WrValid}, 32'd0);
        end
        @(posedge CLK); #1;

        // Randomized batches with random backpressure
        rnd_rdy = 1'b1;
        for (int b = 0; b < 25; b++) begin
            do_clear();
            n = $urandom_range(1, DP);
            for (int i = 0; i < n; i++) send_rand();
            wait_drain();
        end
        rnd_rdy = 1'b0;
        repeat (2) @(posedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
